// File: rtl/credential_entry.sv
// Keypad credential collector: 4 username + 4 password nibbles, backspace/clear/consume.
// Optional idle auto-clear when ENTRY_TIMEOUT_EN is defined (TIMEOUT_CYCLES).
module credential_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digitIn,
  input  logic       btnEnter,
  input  logic       btnBack,
  input  logic       btnClear,
  input  logic       resetCount,
  output logic [3:0] inputCount,
  output logic [3:0] userNameInput0,
  output logic [3:0] userNameInput1,
  output logic [3:0] userNameInput2,
  output logic [3:0] userNameInput3,
  output logic [3:0] passwordInput0,
  output logic [3:0] passwordInput1,
  output logic [3:0] passwordInput2,
  output logic [3:0] passwordInput3,
  output logic       passwordPhase,
  output logic       entryFull
);

  typedef enum logic [1:0] {
    EMPTY,
    USER,
    PASS,
    FULL
  } state_e;

  // bit order: {resetCount, btnClear, btnBack, btnEnter}
  logic [3:0] btn_s1_q, btn_s2_q, btn_prev_q;
  logic [3:0] dig_s1_q, dig_s2_q;
  logic [3:0] pulse;

  logic [7:0][3:0] slot_q, slot_d;
  logic [3:0]      cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [2:0]      back_idx;
  logic            tmo_fire;

  assign pulse    = btn_s2_q & ~btn_prev_q;
  assign back_idx = cnt_q[2:0] - 3'd1;

`ifdef ENTRY_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000;

  logic [31:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d    = tmo_q + 32'd1;
    tmo_fire = (cnt_q != 4'd0) && (tmo_q == TIMEOUT_CYCLES - 32'd1);
    if ((cnt_q == 4'd0) || (|pulse) || tmo_fire)
      tmo_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Clear > Consume > Backspace > Enter; losers are dropped
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (pulse[2] || pulse[3] || tmo_fire) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (pulse[1]) begin
      if (cnt_q != 4'd0) begin
        cnt_d            = cnt_q - 4'd1;
        slot_d[back_idx] = '0;
      end
    end else if (pulse[0]) begin
      if (cnt_q < 4'd8) begin
        cnt_d              = cnt_q + 4'd1;
        slot_d[cnt_q[2:0]] = dig_s2_q;
      end
    end
  end

  always_comb begin
    state_d = FULL;
    if (cnt_d == 4'd0)     state_d = EMPTY;
    else if (cnt_d < 4'd4) state_d = USER;
    else if (cnt_d < 4'd8) state_d = PASS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
      dig_s1_q   <= '0;
      dig_s2_q   <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      state_q    <= EMPTY;
    end else begin
      btn_s1_q   <= {resetCount, btnClear, btnBack, btnEnter};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      dig_s1_q   <= digitIn;
      dig_s2_q   <= dig_s1_q;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  assign inputCount     = cnt_q;
  assign passwordPhase  = (state_q == PASS) || (state_q == FULL);
  assign entryFull      = (state_q == FULL);

  // first digit typed lands in userNameInput3
  assign userNameInput3 = slot_q[0];
  assign userNameInput2 = slot_q[1];
  assign userNameInput1 = slot_q[2];
  assign userNameInput0 = slot_q[3];
  assign passwordInput3 = slot_q[4];
  assign passwordInput2 = slot_q[5];
  assign passwordInput1 = slot_q[6];
  assign passwordInput0 = slot_q[7];

endmodule
